fft_frame_loader: RTL and testbench
===================================

# fft_frame_loader

Parametrised frame sequencer between a sample source (combinational sample ROM or capture buffer) and the `fft` core. It streams one frame of `N_POINTS` samples into the core, waits for `fft_finish`, then either stops or re-arms for the next frame. It adds features the hard-wired 16-point power-up load in the top level lacks: configurable depth and width, start/abort control, continuous mode, a completion timeout and a frame counter.

## Interface
- `DATA_W`, 16: sample width.
- `N_POINTS`, 16: samples per frame; power of two, ≥2.
- `ADDR_W`, `$clog2(N_POINTS)`: address width (derived).
- `START_DELAY`, 4: idle cycles between arming and the first sample; ≥1.
- `TIMEOUT_CYC`, 4096: maximum cycles spent in WAIT before the timeout fires; ≥1.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle arm pulse; honoured only in IDLE.
- `continuous`, in, 1: level; re-arm automatically after each frame.
- `abort`, in, 1: synchronous abort, honoured in every state.
- `src_addr`, out, `ADDR_W`: sample address to the source.
- `src_data`, in, `DATA_W`: sample at `src_addr`, combinational, same cycle.
- `fft_insert`, out, 1: drives `fft.insert_data`.
- `fft_addr`, out, `ADDR_W`: drives `fft.addr`; equals `src_addr`.
- `fft_data`, out, `DATA_W`: drives `fft.data_in`; equals `src_data`, pass-through.
- `fft_finish`, in, 1: completion pulse from the core.
- `frame_done`, out, 1: one-cycle pulse on accepted `fft_finish`.
- `busy`, out, 1: high in any state other than IDLE.
- `timeout`, out, 1: sticky flag; cleared by an accepted `start`.
- `frame_count`, out, 16: accepted frames, wraps at 0xFFFF→0.

## Operation
- States:
  - IDLE → DELAY on `start`.
  - DELAY: counts `START_DELAY` cycles, then → LOAD.
  - LOAD: `fft_insert`=1 for exactly `N_POINTS` consecutive cycles, with `src_addr` 0,1,…,N−1. After address N−1 → WAIT.
  - WAIT: on `fft_finish`, pulse `frame_done`, increment `frame_count`, then → DELAY if `continuous`=1, else → IDLE.
- Timeout: if WAIT lasts `TIMEOUT_CYC` cycles without `fft_finish`, set `timeout`=1 and → IDLE. There is no frame_done and no count increment, even when `continuous`=1.
- `fft_finish` outside WAIT is ignored, including the cycle LOAD presents address N−1.
- `continuous` is sampled only on the WAIT→next transition. Dropping it mid-frame completes the current frame, then the block goes to IDLE.
- `start` while busy is ignored. `start` together with `abort` in IDLE: abort wins and the block stays in IDLE.
- `abort` → IDLE on the next edge. `fft_insert` drops, `src_addr`→0, delay and timeout counters clear. `frame_count` and `timeout` keep their values.
- Address counter is `ADDR_W` wide. The wrap from N−1→0 coincides with LOAD→WAIT, so there is no extra compare stage.

## Timing
- Reset values: state IDLE; `src_addr`=0, `fft_insert`=0, `frame_done`=0, `busy`=0, `timeout`=0, `frame_count`=0. `fft_data` follows `src_data`.
- All outputs are registered except `fft_data` and `busy`; `busy` decodes directly from state.
- `start` accepted at edge k: `busy`=1 from k+1, and the first `fft_insert`=1 is at cycle k+1+`START_DELAY`.
- `fft_finish` seen at edge m: `frame_done`=1 during cycle m+1 and `frame_count` updates at m+1. In continuous mode, the next frame's first sample is at m+1+`START_DELAY`.
- Timeout fires on the `TIMEOUT_CYC`-th WAIT cycle. `timeout`=1 and `busy`=0 from the following cycle.
- Reset asserted mid-LOAD: `fft_insert` drops immediately (asynchronous). A partial frame stays in the core, and the core's own reset must discard it.

## Structure
- Shared package `fft_pkg`: state enum (IDLE, DELAY, LOAD, WAIT), default `DATA_W`/`N_POINTS`, frame counter width constant (16).
- Single module, no sub-modules. The delay counter and timeout counter share one register, width `$clog2(max(START_DELAY,TIMEOUT_CYC)+1)`.

## Test plan
- Reset, then `start` at cycle 10 with `START_DELAY`=4 and N=16 → `fft_insert` high for cycles 15–30, `src_addr` 0..15, `fft_data`=ROM[addr] each cycle. `fft_finish` 20 cycles later → one `frame_done` pulse, `frame_count`=1, `busy`=0.
- `continuous`=1, three `fft_finish` pulses → three LOAD bursts, each starting exactly `START_DELAY`+1 cycles after its finish; `frame_count`=3. Drop `continuous` during the 3rd LOAD → IDLE after the 3rd finish.
- `TIMEOUT_CYC`=64, no `fft_finish` → `timeout`=1 after 64 WAIT cycles, IDLE, `frame_count` unchanged. Next `start` clears `timeout`.
- `abort` at the 7th LOAD cycle → `fft_insert`=0 and `src_addr`=0 next cycle. `start` then reloads a full 16-sample frame from address 0.
- Spurious `fft_finish` during DELAY and LOAD, plus `start` during WAIT → no state change, no `frame_done`. `start` and `abort` in the same IDLE cycle → stays IDLE.
- `N_POINTS`=64, `DATA_W`=12 and `frame_count` preset near wrap: 64 samples with addresses 0..63, and `frame_count` wraps 0xFFFF→0x0000 on the finish.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT frame loader: sequencer state encoding,
// default sample width / frame depth, frame counter width, and a small
// constant helper used to size shared counters.
// ---------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        LOAD  = 2'd2,
        WAIT  = 2'd3
    } loader_state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_N_POINTS = 16;
    localparam int FRAME_CNT_W  = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fft_frame_loader.sv
// ---------------------------------------------------------------------------
// fft_frame_loader
// Streams one frame of N_POINTS samples from a combinational sample source
// into the fft core, waits for the core's completion pulse, then stops or
// re-arms (continuous mode). Provides start/abort control, a completion
// timeout and a wrapping frame counter.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle arm pulse, honoured only in IDLE
//   continuous          level; re-arm after each completed frame
//   abort               synchronous return to IDLE from any state
//   src_addr/src_data   sample source address out, sample in (same cycle)
//   fft_insert          core insert strobe, high for N_POINTS cycles
//   fft_addr/fft_data   core address (= src_addr) and data (= src_data)
//   fft_finish          completion pulse from the core (accepted in WAIT)
//   frame_done          one-cycle pulse per accepted completion
//   busy                high whenever not IDLE
//   timeout             sticky; set when WAIT expires, cleared by start
//   frame_count         accepted frames, wraps modulo 2^16
// ---------------------------------------------------------------------------
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int N_POINTS    = DEF_N_POINTS,
    parameter int ADDR_W      = $clog2(N_POINTS),
    parameter int START_DELAY = 4,
    parameter int TIMEOUT_CYC = 4096,
    // Reset value of frame_count; normally zero. A value near the top of
    // the range makes the wrap reachable without running 65k frames.
    parameter logic [FRAME_CNT_W-1:0] COUNT_INIT = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   abort,
    output logic [ADDR_W-1:0]      src_addr,
    input  logic [DATA_W-1:0]      src_data,
    output logic                   fft_insert,
    output logic [ADDR_W-1:0]      fft_addr,
    output logic [DATA_W-1:0]      fft_data,
    input  logic                   fft_finish,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   timeout,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    // One counter serves both the start delay (DELAY) and the completion
    // timeout (WAIT); the two phases never overlap.
    localparam int CNT_W = $clog2(max_int(START_DELAY, TIMEOUT_CYC) + 1);

    localparam logic [CNT_W-1:0]  DELAY_LAST   = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST    = ADDR_W'(N_POINTS - 1);

    loader_state_t          state_reg,   state_next;
    logic [CNT_W-1:0]       cnt_reg,     cnt_next;
    logic [ADDR_W-1:0]      addr_reg,    addr_next;
    logic                   insert_reg,  insert_next;
    logic                   done_reg,    done_next;
    logic                   timeout_reg, timeout_next;
    logic [FRAME_CNT_W-1:0] count_reg,   count_next;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            insert_reg  <= 1'b0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            count_reg   <= COUNT_INIT;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            insert_reg  <= insert_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
            count_reg   <= count_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        done_next    = 1'b0;
        timeout_next = timeout_reg;
        count_next   = count_reg;

        if (abort) begin
            // Abort beats everything, including a simultaneous start or
            // finish; counters clear but frame_count/timeout are kept.
            state_next = IDLE;
            cnt_next   = '0;
            addr_next  = '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next   = DELAY;
                        cnt_next     = '0;
                        timeout_next = 1'b0;
                    end
                end

                DELAY: begin
                    if (cnt_reg == DELAY_LAST) begin
                        state_next = LOAD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end

                LOAD: begin
                    // N_POINTS is a power of two, so the natural wrap of
                    // the address register lands on 0 exactly as the
                    // frame ends and WAIT begins.
                    addr_next = addr_reg + ADDR_W'(1);
                    if (addr_reg == ADDR_LAST) begin
                        state_next = WAIT;
                        cnt_next   = '0;
                    end
                end

                WAIT: begin
                    if (fft_finish) begin
                        done_next  = 1'b1;
                        count_next = count_reg + FRAME_CNT_W'(1);
                        cnt_next   = '0;
                        state_next = continuous ? DELAY : IDLE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        // Give up on the core; never auto re-arm here.
                        timeout_next = 1'b1;
                        cnt_next     = '0;
                        state_next   = IDLE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end

                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    addr_next  = '0;
                end
            endcase
        end

        // Registered strobe: high exactly while the sequencer is in LOAD.
        insert_next = (state_next == LOAD);
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign src_addr    = addr_reg;
    assign fft_addr    = addr_reg;
    assign fft_data    = src_data;
    assign fft_insert  = insert_reg;
    assign frame_done  = done_reg;
    assign busy        = (state_reg != IDLE);
    assign timeout     = timeout_reg;
    assign frame_count = count_reg;

endmodule

// File: tb/tb_fft_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_loader
// Self-checking bench for fft_frame_loader. Instance A: 16 x 16-bit frames,
// START_DELAY=4, TIMEOUT_CYC=64. Instance B: 64 x 12-bit frames with the
// frame counter starting at 0xFFFE to reach the wrap.
// Expected behaviour is expressed as a timeline: t counts cycles since the
// arming edge (accepted start, or accepted finish in continuous mode).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_frame_loader;

    localparam int S   = 4;
    localparam int N   = 16;
    localparam int TO  = 64;
    localparam int NB  = 64;
    localparam int DWB = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic        start_a, cont_a, abort_a, finish_a;
    logic [3:0]  src_addr_a, fft_addr_a;
    logic [15:0] src_data_a, fft_data_a;
    logic        insert_a, done_a, busy_a, timeout_a;
    logic [15:0] count_a;
    logic [15:0] rom_a [N];
    assign src_data_a = rom_a[src_addr_a];

    fft_frame_loader #(
        .DATA_W(16), .N_POINTS(N), .START_DELAY(S), .TIMEOUT_CYC(TO)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a),
        .abort(abort_a), .src_addr(src_addr_a), .src_data(src_data_a),
        .fft_insert(insert_a), .fft_addr(fft_addr_a), .fft_data(fft_data_a),
        .fft_finish(finish_a), .frame_done(done_a), .busy(busy_a),
        .timeout(timeout_a), .frame_count(count_a)
    );

    // ---------------- instance B ----------------
    logic           start_b, cont_b, abort_b, finish_b;
    logic [5:0]     src_addr_b, fft_addr_b;
    logic [DWB-1:0] src_data_b, fft_data_b;
    logic           insert_b, done_b, busy_b, timeout_b;
    logic [15:0]    count_b;
    logic [DWB-1:0] rom_b [NB];
    assign src_data_b = rom_b[src_addr_b];

    fft_frame_loader #(
        .DATA_W(DWB), .N_POINTS(NB), .START_DELAY(S), .COUNT_INIT(16'hFFFE)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b),
        .abort(abort_b), .src_addr(src_addr_b), .src_data(src_data_b),
        .fft_insert(insert_b), .fft_addr(fft_addr_b), .fft_data(fft_data_b),
        .fft_finish(finish_b), .frame_done(done_b), .busy(busy_b),
        .timeout(timeout_b), .frame_count(count_b)
    );

    int          total;
    int          bad;
    int          exp_count_a;
    logic [15:0] exp_count_b;

    // Reference view of A at t cycles after arming:
    // {busy, insert, src_addr, fft_addr, fft_data}.
    function automatic logic [25:0] view_a(input int t);
        logic       ins;
        logic [3:0] a;
        ins = (t >= S) && (t < S + N);
        a   = ins ? 4'(t - S) : 4'd0;
        return {1'b1, ins, a, a, rom_a[a]};
    endfunction

    function automatic logic [25:0] view_b(input int t);
        logic       ins;
        logic [5:0] a;
        ins = (t >= S) && (t < S + NB);
        a   = ins ? 6'(t - S) : 6'd0;
        return {1'b1, ins, a, a, rom_b[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 0; cont_a = 0; abort_a = 0; finish_a = 0;
        start_b = 0; cont_b = 0; abort_b = 0; finish_b = 0;
        for (int i = 0; i < N; i++)  rom_a[i] = 16'($urandom);
        for (int i = 0; i < NB; i++) rom_b[i] = DWB'($urandom);
        tick(); tick();
        total++;
        if ({busy_a, insert_a, src_addr_a, done_a, timeout_a, count_a} !== 24'h0) begin
            bad++;
            $display("FAIL reset_hold_a got=%h exp=0",
                     {busy_a, insert_a, src_addr_a, done_a, timeout_a, count_a});
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({busy_a, insert_a, src_addr_a, done_a, timeout_a, count_a} !== 24'h0) begin
            bad++;
            $display("FAIL reset_rel_a got=%h exp=0",
                     {busy_a, insert_a, src_addr_a, done_a, timeout_a, count_a});
        end
        total++;
        if (fft_data_a !== rom_a[0]) begin
            bad++;
            $display("FAIL reset_data_a got=%h exp=%h", fft_data_a, rom_a[0]);
        end
        total++;
        if ({busy_b, insert_b, src_addr_b, done_b, timeout_b, count_b} !== {10'h0, 16'hFFFE}) begin
            bad++;
            $display("FAIL reset_b got=%h exp=%h",
                     {busy_b, insert_b, src_addr_b, done_b, timeout_b, count_b}, {10'h0, 16'hFFFE});
        end
        exp_count_a = 0;
        exp_count_b = 16'hFFFE;
        $display("txn reset: released");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single_frame();
        logic [25:0] got;
        int idle_cyc;
        idle_cyc = $urandom_range(2, 6);
        for (int i = 0; i < idle_cyc; i++) begin
            total++;
            if ({busy_a, insert_a} !== 2'b00) begin
                bad++;
                $display("FAIL single_idle got=%b exp=00", {busy_a, insert_a});
            end
            tick();
        end
        arm_a();
        for (int t = 0; t < S + N + 20; t++) begin
            got = {busy_a, insert_a, src_addr_a, fft_addr_a, fft_data_a};
            total++;
            if (got !== view_a(t) || done_a !== 1'b0) begin
                bad++;
                $display("FAIL single_t t=%0d got=%h/%b exp=%h/0", t, got, done_a, view_a(t));
            end
            if (t == S + N + 19) finish_a = 1'b1;
            tick();
        end
        finish_a = 1'b0;
        exp_count_a++;
        total++;
        if ({done_a, busy_a, count_a} !== {1'b1, 1'b0, 16'(exp_count_a)}) begin
            bad++;
            $display("FAIL single_done got=%b/%b/%0d exp=1/0/%0d", done_a, busy_a, count_a, exp_count_a);
        end
        tick();
        total++;
        if ({done_a, busy_a} !== 2'b00) begin
            bad++;
            $display("FAIL single_pulse got=%b exp=00", {done_a, busy_a});
        end
        $display("txn single: frame_count=%0d", count_a);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_continuous();
        logic [25:0] got;
        logic        exp_done;
        int          gap;
        int          drop_t;
        cont_a = 1'b1;
        drop_t = S + $urandom_range(0, N - 1);
        arm_a();
        for (int f = 0; f < 3; f++) begin
            gap = $urandom_range(0, 30);
            for (int t = 0; t <= S + N + gap; t++) begin
                got      = {busy_a, insert_a, src_addr_a, fft_addr_a, fft_data_a};
                exp_done = (t == 0) && (f > 0);
                total++;
                if (got !== view_a(t) || done_a !== exp_done) begin
                    bad++;
                    $display("FAIL cont_t f=%0d t=%0d got=%h/%b exp=%h/%b",
                             f, t, got, done_a, view_a(t), exp_done);
                end
                if (f == 2 && t == drop_t) cont_a = 1'b0;
                if (t == S + N + gap) finish_a = 1'b1;
                tick();
            end
            finish_a = 1'b0;
            exp_count_a++;
            total++;
            if ({done_a, busy_a, count_a} !== {1'b1, (f < 2), 16'(exp_count_a)}) begin
                bad++;
                $display("FAIL cont_done f=%0d got=%b/%b/%0d exp=1/%b/%0d",
                         f, done_a, busy_a, count_a, (f < 2), exp_count_a);
            end
            $display("txn continuous: frame=%0d gap=%0d frame_count=%0d", f, gap, count_a);
        end
        tick();
        total++;
        if ({busy_a, insert_a, done_a} !== 3'b000) begin
            bad++;
            $display("FAIL cont_idle got=%b exp=000", {busy_a, insert_a, done_a});
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_timeout();
        logic [25:0] got;
        cont_a = 1'b1;
        arm_a();
        for (int t = 0; t < S + N + TO; t++) begin
            got = {busy_a, insert_a, src_addr_a, fft_addr_a, fft_data_a};
            total++;
            if (got !== view_a(t) || {done_a, timeout_a} !== 2'b00) begin
                bad++;
                $display("FAIL tmo_t t=%0d got=%h/%b exp=%h/00", t, got, {done_a, timeout_a}, view_a(t));
            end
            tick();
        end
        total++;
        if ({busy_a, timeout_a, done_a, insert_a, count_a} !== {4'b0100, 16'(exp_count_a)}) begin
            bad++;
            $display("FAIL tmo_fire got=%b/%0d exp=0100/%0d",
                     {busy_a, timeout_a, done_a, insert_a}, count_a, exp_count_a);
        end
        tick(); tick(); tick();
        total++;
        if ({busy_a, timeout_a} !== 2'b01) begin
            bad++;
            $display("FAIL tmo_norearm got=%b exp=01", {busy_a, timeout_a});
        end
        cont_a = 1'b0;
        arm_a();
        total++;
        if ({busy_a, timeout_a} !== 2'b10) begin
            bad++;
            $display("FAIL tmo_clear got=%b exp=10", {busy_a, timeout_a});
        end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        total++;
        if ({busy_a, timeout_a, count_a} !== {2'b00, 16'(exp_count_a)}) begin
            bad++;
            $display("FAIL tmo_abort got=%b/%0d exp=00/%0d", {busy_a, timeout_a}, count_a, exp_count_a);
        end
        $display("txn timeout: fired and cleared, frame_count=%0d", count_a);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_abort();
        logic [25:0] got;
        int abort_t;
        int gap;
        for (int rep = 0; rep < 2; rep++) begin
            abort_t = (rep == 0) ? S + 6 : $urandom_range(0, S + N + 10);
            arm_a();
            for (int t = 0; t <= abort_t; t++) begin
                got = {busy_a, insert_a, src_addr_a, fft_addr_a, fft_data_a};
                total++;
                if (got !== view_a(t)) begin
                    bad++;
                    $display("FAIL abort_t rep=%0d t=%0d got=%h exp=%h", rep, t, got, view_a(t));
                end
                if (t == abort_t) abort_a = 1'b1;
                tick();
            end
            abort_a = 1'b0;
            total++;
            if ({busy_a, insert_a, src_addr_a, fft_addr_a, done_a, count_a} !== {11'h0, 16'(exp_count_a)}) begin
                bad++;
                $display("FAIL abort_idle rep=%0d got=%b/%h/%h/%b/%0d exp=00/0/0/0/%0d",
                         rep, {busy_a, insert_a}, src_addr_a, fft_addr_a, done_a, count_a, exp_count_a);
            end
            $display("txn abort: at t=%0d", abort_t);
        end
        gap = $urandom_range(0, 10);
        arm_a();
        for (int t = 0; t <= S + N + gap; t++) begin
            got = {busy_a, insert_a, src_addr_a, fft_addr_a, fft_data_a};
            total++;
            if (got !== view_a(t)) begin
                bad++;
                $display("FAIL abort_reload t=%0d got=%h exp=%h", t, got, view_a(t));
            end
            if (t == S + N + gap) finish_a = 1'b1;
            tick();
        end
        finish_a = 1'b0;
        exp_count_a++;
        total++;
        if ({done_a, busy_a, count_a} !== {2'b10, 16'(exp_count_a)}) begin
            bad++;
            $display("FAIL abort_reload_done got=%b/%0d exp=10/%0d", {done_a, busy_a}, count_a, exp_count_a);
        end
        $display("txn reload: frame_count=%0d", count_a);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_spurious();
        logic [25:0] got;
        arm_a();
        for (int t = 0; t <= S + N + 5; t++) begin
            got = {busy_a, insert_a, src_addr_a, fft_addr_a, fft_data_a};
            total++;
            if (got !== view_a(t) || done_a !== 1'b0) begin
                bad++;
                $display("FAIL spur_t t=%0d got=%h/%b exp=%h/0", t, got, done_a, view_a(t));
            end
            finish_a = (t == 1) || (t == S + 3) || (t == S + N - 1) || (t == S + N + 5);
            start_a  = (t == S + N + 2);
            tick();
        end
        finish_a = 1'b0;
        start_a  = 1'b0;
        exp_count_a++;
        total++;
        if ({done_a, busy_a, count_a} !== {2'b10, 16'(exp_count_a)}) begin
            bad++;
            $display("FAIL spur_done got=%b/%0d exp=10/%0d", {done_a, busy_a}, count_a, exp_count_a);
        end
        tick();
        finish_a = 1'b1;
        tick();
        finish_a = 1'b0;
        total++;
        if ({done_a, busy_a, count_a} !== {2'b00, 16'(exp_count_a)}) begin
            bad++;
            $display("FAIL spur_idle_finish got=%b/%0d exp=00/%0d", {done_a, busy_a}, count_a, exp_count_a);
        end
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        for (int i = 0; i < S + 3; i++) begin
            total++;
            if ({busy_a, insert_a} !== 2'b00) begin
                bad++;
                $display("FAIL spur_start_abort i=%0d got=%b exp=00", i, {busy_a, insert_a});
            end
            tick();
        end
        $display("txn spurious: frame_count=%0d", count_a);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [25:0] got;
        int gap;
        for (int k = 0; k < 3; k++) begin
            gap = $urandom_range(0, 12);
            arm_a();
            for (int t = 0; t <= S + N + gap; t++) begin
                got = {busy_a, insert_a, src_addr_a, fft_addr_a, fft_data_a};
                total++;
                if (got !== view_a(t)) begin
                    bad++;
                    $display("FAIL b2b_t k=%0d t=%0d got=%h exp=%h", k, t, got, view_a(t));
                end
                if (t == S + N + gap) finish_a = 1'b1;
                tick();
            end
            finish_a = 1'b0;
            exp_count_a++;
            total++;
            if ({done_a, busy_a, count_a} !== {2'b10, 16'(exp_count_a)}) begin
                bad++;
                $display("FAIL b2b_done k=%0d got=%b/%0d exp=10/%0d", k, {done_a, busy_a}, count_a, exp_count_a);
            end
            $display("txn back_to_back: k=%0d gap=%0d frame_count=%0d", k, gap, count_a);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid_load();
        logic [25:0] got;
        int ld;
        ld = $urandom_range(0, N - 2);
        arm_a();
        for (int t = 0; t <= S + ld; t++) begin
            got = {busy_a, insert_a, src_addr_a, fft_addr_a, fft_data_a};
            total++;
            if (got !== view_a(t)) begin
                bad++;
                $display("FAIL rstmid_t t=%0d got=%h exp=%h", t, got, view_a(t));
            end
            if (t < S + ld) tick();
        end
        // Assert reset between clock edges: outputs must clear at once.
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy_a, insert_a, src_addr_a, done_a, timeout_a, count_a} !== 24'h0) begin
            bad++;
            $display("FAIL rstmid_async got=%h exp=0",
                     {busy_a, insert_a, src_addr_a, done_a, timeout_a, count_a});
        end
        tick();
        rst_n = 1'b1;
        tick();
        exp_count_a = 0;
        exp_count_b = 16'hFFFE;
        total++;
        if ({busy_a, insert_a, count_b} !== {2'b00, exp_count_b}) begin
            bad++;
            $display("FAIL rstmid_after got=%b/%h exp=00/%h", {busy_a, insert_a}, count_b, exp_count_b);
        end
        $display("txn reset_mid_load: at sample %0d", ld);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_wrap();
        logic [25:0] got;
        int gap;
        cont_b  = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int f = 0; f < 2; f++) begin
            gap = $urandom_range(0, 10);
            for (int t = 0; t <= S + NB + gap; t++) begin
                got = {busy_b, insert_b, src_addr_b, fft_addr_b, fft_data_b};
                total++;
                if (got !== view_b(t)) begin
                    bad++;
                    $display("FAIL wrap_t f=%0d t=%0d got=%h exp=%h", f, t, got, view_b(t));
                end
                if (f == 1 && t == S + 2) cont_b = 1'b0;
                if (t == S + NB + gap) finish_b = 1'b1;
                tick();
            end
            finish_b    = 1'b0;
            exp_count_b = exp_count_b + 16'd1;
            total++;
            if ({done_b, busy_b, count_b} !== {1'b1, (f == 0), exp_count_b}) begin
                bad++;
                $display("FAIL wrap_done f=%0d got=%b/%h exp=1%b/%h",
                         f, {done_b, busy_b}, count_b, (f == 0), exp_count_b);
            end
            $display("txn wrap: frame=%0d frame_count=%h", f, count_b);
        end
        total++;
        if (count_b !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_zero got=%h exp=0000", count_b);
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_frame();
        test_continuous();
        test_timeout();
        test_abort();
        test_spurious();
        test_back_to_back();
        test_reset_mid_load();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
